// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode stage, the immediate generator and execute.
// master = the driver of instructions and consumer of immediates; slave = the generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SRC_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [SRC_W-1:0] imm_src;
    logic             auto_sel;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ext;
    logic [SRC_W-1:0] src;
    logic             illegal;

    modport master (
        output in_valid, instr, imm_src, auto_sel, out_ready,
        input  in_ready, out_valid, ext, src, illegal
    );

    modport slave (
        input  in_valid, instr, imm_src, auto_sel, out_ready,
        output in_ready, out_valid, ext, src, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with output register and one-entry skid buffer.
// Define IMM_ZICSR_EN to enable format Z (zero-extended CSR uimm in Instr[19:15]).
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SRC_W = 3
) (
    input logic              clk_i,
    input logic              rst_i,
    imm_gen_pipe_if.slave    bus_io
);
    localparam logic [SRC_W-1:0] FmtI   = SRC_W'(0);
    localparam logic [SRC_W-1:0] FmtS   = SRC_W'(1);
    localparam logic [SRC_W-1:0] FmtB   = SRC_W'(2);
    localparam logic [SRC_W-1:0] FmtJ   = SRC_W'(3);
    localparam logic [SRC_W-1:0] FmtU   = SRC_W'(4);
    localparam logic [SRC_W-1:0] FmtZ   = SRC_W'(5);
    localparam logic [SRC_W-1:0] FmtBad = SRC_W'(7);

    typedef struct packed {
        logic [XLEN-1:0]  ext;
        logic [SRC_W-1:0] src;
        logic             ill;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d, skid_q, skid_d, new_entry;

    logic [31:0]      instr;
    logic [SRC_W-1:0] res_src;
    logic             res_ill;
    logic [31:0]      imm32;
    logic             sgn;
    logic             in_xfer, out_xfer;

    assign instr = bus_io.instr;

    // Format resolution; auto-decode misses report an all-ones select.
    always_comb begin
        res_src = bus_io.imm_src;
        if (bus_io.auto_sel) begin
            case (instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: res_src = FmtI;
                7'b0100011:             res_src = FmtS;
                7'b1100011:             res_src = FmtB;
                7'b1101111:             res_src = FmtJ;
                7'b0110111, 7'b0010111: res_src = FmtU;
`ifdef IMM_ZICSR_EN
                7'b1110011:             res_src = instr[14] ? FmtZ : FmtI;
`else
                7'b1110011:             res_src = FmtI;
`endif
                default:                res_src = FmtBad;
            endcase
        end
    end

    always_comb begin
        imm32   = '0;
        sgn     = instr[31];
        res_ill = 1'b0;
        case (res_src)
            FmtI: imm32 = {{20{instr[31]}}, instr[31:20]};
            FmtS: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FmtJ: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                           1'b0};
            FmtU: imm32 = {instr[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
            FmtZ: begin
                imm32 = {27'b0, instr[19:15]};
                sgn   = 1'b0;
            end
`endif
            default: begin
                sgn     = 1'b0;
                res_ill = 1'b1;
            end
        endcase
    end

    if (XLEN == 64) begin : g_x64
        assign new_entry.ext = {{32{sgn}}, imm32};
    end else begin : g_x32
        assign new_entry.ext = imm32;
    end
    assign new_entry.src = res_src;
    assign new_entry.ill = res_ill;

    assign bus_io.in_ready  = (state_q != StFull);
    assign bus_io.out_valid = (state_q != StEmpty);
    assign bus_io.ext       = out_q.ext;
    assign bus_io.src       = out_q.src;
    assign bus_io.illegal   = out_q.ill;

    assign in_xfer  = bus_io.in_valid & bus_io.in_ready;
    assign out_xfer = bus_io.out_valid & bus_io.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: if (in_xfer) begin
                out_d   = new_entry;
                state_d = StOne;
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    out_d = new_entry;
                end else if (in_xfer) begin
                    skid_d  = new_entry;
                    state_d = StFull;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: if (out_xfer) begin
                out_d   = skid_q;
                state_d = StOne;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: vector table, backpressure, reset and a 64-bit instance.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .SRC_W(3)) bus ();
    imm_gen_pipe_if #(.XLEN(64), .SRC_W(3)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .SRC_W(3)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    imm_gen_pipe #(.XLEN(64), .SRC_W(3)) dut64 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus64)
    );

    typedef struct {
        logic        auto_sel;
        logic [2:0]  src;
        logic [31:0] instr;
        logic [31:0] ext;
        logic [2:0]  exp_src;
        logic        ill;
        logic        chk_src;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic [2:0] s, input logic [31:0] ins);
        bus.in_valid = 1'b1;
        bus.auto_sel = a;
        bus.imm_src  = s;
        bus.instr    = ins;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 3'd0, 32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 3'd0, 32'h001000EF, 32'h00000800, 3'd3, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 3'd7, 32'hFFF00093, 32'h00000000, 3'd7, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 3'd0, 32'h002081B3, 32'h00000000, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 3'd1, 32'hFE112C23, 32'hFFFFFFF8, 3'd1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'd0, 32'h123450B7, 32'h12345000, 3'd4, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'd0, 32'h7FF00093, 32'h000007FF, 3'd0, 1'b0, 1'b1};
`ifdef IMM_ZICSR_EN
        vecs[8]  = '{1'b0, 3'd5, 32'h000FE073, 32'h0000001F, 3'd5, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 3'd0, 32'h000FE073, 32'h0000001F, 3'd5, 1'b0, 1'b1};
`else
        vecs[8]  = '{1'b0, 3'd5, 32'h000FE073, 32'h00000000, 3'd5, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 3'd0, 32'h000FE073, 32'h00000000, 3'd0, 1'b0, 1'b1};
`endif
        vecs[10] = '{1'b1, 3'd0, 32'h80002083, 32'hFFFFF800, 3'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'd0, 32'h0010009B, 32'h00000001, 3'd0, 1'b0, 1'b1};

        bus.in_valid = 1'b0; bus.auto_sel = 1'b0; bus.imm_src = '0; bus.instr = '0;
        bus.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.auto_sel = 1'b0; bus64.imm_src = '0; bus64.instr = '0;
        bus64.out_ready = 1'b1;

        repeat (2) tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_ext", 64'(bus.ext), 64'd0);
        chk("rst_src", 64'(bus.src), 64'd0);
        chk("rst_ill", 64'(bus.illegal), 64'd0);
        rst = 1'b0;

        // Back-to-back vectors with Ready_i=1: one result per cycle.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].auto_sel, vecs[i].src, vecs[i].instr);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_ext", i), 64'(bus.ext), 64'(vecs[i].ext));
            chk($sformatf("vec%0d_ill", i), 64'(bus.illegal), 64'(vecs[i].ill));
            if (vecs[i].chk_src)
                chk($sformatf("vec%0d_src", i), 64'(bus.src), 64'(vecs[i].exp_src));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: three words, immediates 1, 2, 3.
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'h00100093);
        chk("bp_rdy_a", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 3'd0, 32'h00200093);
        chk("bp_rdy_b", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 3'd0, 32'h00300093);
        chk("bp_full_rdy", 64'(bus.in_ready), 64'd0);
        chk("bp_full_ext", 64'(bus.ext), 64'd1);
        tick();
        chk("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_ext", 64'(bus.ext), 64'd1);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out2", 64'(bus.ext), 64'd2);
        chk("bp_rdy_back", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_out3", 64'(bus.ext), 64'd3);
        chk("bp_out3_valid", 64'(bus.out_valid), 64'd1);
        tick();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Reset while FULL, with a simultaneous offered word that must be dropped.
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'h00100093);
        tick();
        drive(1'b0, 3'd0, 32'h00200093);
        tick();
        chk("mr_full", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'h00400093);
        bus.out_ready = 1'b1;
        tick();
        chk("mr_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_ready", 64'(bus.in_ready), 64'd1);
        chk("mr_ext", 64'(bus.ext), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("mr_dropped", 64'(bus.out_valid), 64'd0);
        drive(1'b0, 3'd0, 32'h00500093);
        tick();
        bus.in_valid = 1'b0;
        chk("mr_single_valid", 64'(bus.out_valid), 64'd1);
        chk("mr_single_ext", 64'(bus.ext), 64'd5);
        tick();
        chk("mr_no_stale", 64'(bus.out_valid), 64'd0);

        // XLEN=64: lui sign-extends bit 31 through bit 63.
        bus64.in_valid = 1'b1;
        bus64.auto_sel = 1'b1;
        bus64.instr    = 32'h800000B7;
        tick();
        bus64.in_valid = 1'b0;
        chk("x64_valid", 64'(bus64.out_valid), 64'd1);
        chk("x64_lui", bus64.ext, 64'hFFFFFFFF80000000);
        chk("x64_src", 64'(bus64.src), 64'd4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
